// File: rtl/frame_buffer_reader.sv
// frame_buffer_reader: scans one frame out of LRAM port B into a valid/ready pixel stream
// with line/frame sideband, absorbing the fixed read latency via a credit-limited FIFO.
module frame_buffer_reader #(
   parameter int RADDR_WIDTH  = 14,
   parameter int RADDR_DEPTH  = 16384,
   parameter int RDATA_WIDTH  = 32,
   parameter int READ_LATENCY = 2,
   parameter int LINE_WORDS   = 160,
   parameter int FRAME_LINES  = 120,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   start_i,
   input  logic                   abort_i,
   input  logic [RADDR_WIDTH-1:0] base_addr_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   rd_clk_en_o,
   output logic                   rdout_clken_o,
   output logic [RADDR_WIDTH-1:0] rd_addr_o,
   input  logic [RDATA_WIDTH-1:0] rd_data_i,
   output logic [RDATA_WIDTH-1:0] pix_data_o,
   output logic                   pix_valid_o,
   input  logic                   pix_ready_i,
   output logic                   pix_sol_o,
   output logic                   pix_eof_o
);
   localparam int CW = $clog2(LINE_WORDS > FRAME_LINES ? LINE_WORDS : FRAME_LINES) + 1;
   localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
   localparam int FW = $clog2(FIFO_DEPTH + 1);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [CW-1:0] COL_LAST = CW'(LINE_WORDS - 1);
   localparam logic [CW-1:0] LINE_LAST = CW'(FRAME_LINES - 1);
   localparam logic [RADDR_WIDTH-1:0] ADDR_LAST = RADDR_WIDTH'(RADDR_DEPTH - 1);
   localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
   localparam logic [FW:0] DEPTH_C = (FW + 1)'(FIFO_DEPTH);

   logic [1:0]              state;
   logic [CW-1:0]           col, line;
   logic [RADDR_WIDTH-1:0]  addr;
   logic [READ_LATENCY-1:0] vld, vsol, veof;
   logic [RDATA_WIDTH-1:0]  fd [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0]   fs, fe;
   logic [PW-1:0]           wp, rp;
   logic [FW-1:0]           cnt, in_flight;
   logic                    issue, last, push, pop, finish;

   assign in_flight = FW'($countones(vld));
   assign last      = (col == COL_LAST) && (line == LINE_LAST);
   // words already in flight or buffered are the credits spent; a same-cycle pop is not counted
   assign issue     = (state == FETCH) && !abort_i && (({1'b0, in_flight} + {1'b0, cnt}) < DEPTH_C);
   assign push      = vld[READ_LATENCY-1];
   assign pop       = pix_valid_o && pix_ready_i;
   assign finish    = (state == DRAIN) && (in_flight == '0) && (cnt == (pop ? FW'(1) : FW'(0)));

   assign busy_o        = state != IDLE;
   assign rdout_clken_o = busy_o;
   assign rd_clk_en_o   = issue;
   assign rd_addr_o     = addr;
   assign pix_valid_o   = cnt != '0;
   assign pix_data_o    = pix_valid_o ? fd[rp] : '0;
   assign pix_sol_o     = pix_valid_o & fs[rp];
   assign pix_eof_o     = pix_valid_o & fe[rp];

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state  <= IDLE;
         col    <= '0;
         line   <= '0;
         addr   <= '0;
         vld    <= '0;
         vsol   <= '0;
         veof   <= '0;
         fs     <= '0;
         fe     <= '0;
         wp     <= '0;
         rp     <= '0;
         cnt    <= '0;
         done_o <= 1'b0;
      end else begin
         done_o <= 1'b0;
         if (abort_i) begin
            state <= IDLE;
            vld   <= '0;
            wp    <= '0;
            rp    <= '0;
            cnt   <= '0;
         end else begin
            vld  <= (vld << 1) | READ_LATENCY'(issue);
            vsol <= (vsol << 1) | READ_LATENCY'(col == '0);
            veof <= (veof << 1) | READ_LATENCY'(last);
            if (push) begin
               fs[wp] <= vsol[READ_LATENCY-1];
               fe[wp] <= veof[READ_LATENCY-1];
               wp     <= (wp == PTR_LAST) ? '0 : wp + 1'b1;
            end
            if (pop) rp <= (rp == PTR_LAST) ? '0 : rp + 1'b1;
            cnt <= cnt + FW'(push) - FW'(pop);
            if (state == IDLE && start_i) begin
               state <= FETCH;
               addr  <= base_addr_i;
               col   <= '0;
               line  <= '0;
            end
            if (issue) begin
               addr <= (addr == ADDR_LAST) ? '0 : addr + 1'b1;
               col  <= (col == COL_LAST) ? '0 : col + 1'b1;
               if (col == COL_LAST) line <= (line == LINE_LAST) ? '0 : line + 1'b1;
               if (last) state <= DRAIN;
            end
            if (finish) begin
               state  <= IDLE;
               done_o <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push && !abort_i) fd[wp] <= rd_data_i;
   end
endmodule
